morse_char_sequencer: RTL and testbench
=======================================

// Module: morse_char_sequencer
// PURPOSE
//  Character-level Morse keyer controller that sequences the tone datapath. Accepts
//  ASCII characters over a valid/ready handshake, looks up each Morse code and keys
//  the square-wave tone output with ITU timing: dot 1u, dash 3u, element gap 1u,
//  character gap 3u, word gap 7u. Sits between a message source and the speaker pin.
// PARAMETERS
//  UNIT_DIV  12500000  iCLK cycles per Morse unit (250 ms at 50 MHz); must be >= 2
//  TONE_BIT  17        bit of the free-running tone counter driven to oSOUND
// PORTS
//  iCLK     in   1  system clock; only clock, all logic on posedge
//  iRST_N   in   1  reset, synchronous, active-low
//  iCHAR    in   8  ASCII character to send
//  iVALID   in   1  iCHAR is valid
//  oREADY   out  1  sequencer can accept a character this cycle
//  oKEY     out  1  tone enable (1 = mark), registered
//  oSOUND   out  1  oKEY AND tone_cnt[TONE_BIT]
//  oBUSY    out  1  a character or gap is being timed
// BEHAVIOUR
//  - Reset: any posedge with iRST_N=0 -> state IDLE, prescaler=0, tone_cnt=0, oKEY=0;
//    hence oBUSY=0, oSOUND=0, oREADY=1. Applies mid-element: key drops at that edge.
//  - Handshake: transfer when iVALID && oREADY. oREADY = (state==IDLE). iCHAR sampled
//    only on transfer; iVALID while busy is ignored (held, not lost by this block).
//  - Codebook: 'A'-'Z', '0'-'9'; 'a'-'z' folded to uppercase. Entry = len[2:0] (1..5),
//    pat[4:0] (1=dash, element 0 at pat[len-1], MSB-first). ' ' = word space.
//    Any other code: consumed, no timing, oREADY stays 1, oKEY stays 0.
//  - States: IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP.
//    IDLE --valid letter/digit--> MARK (element 0); --' '--> WORD_GAP (4u; with the
//    preceding char gap this totals 7u). MARK (1u dot / 3u dash, oKEY=1) -> ELEM_GAP
//    (1u) if elements remain, else CHAR_GAP (3u). ELEM_GAP -> MARK (next element).
//    CHAR_GAP / WORD_GAP -> IDLE.
//  - Timing: on transfer edge T, prescaler cleared and state/oKEY updated at T, so
//    oKEY=1 from T+1. Each state lasts exactly units*UNIT_DIV cycles. Prescaler counts
//    0..UNIT_DIV-1, unit tick at UNIT_DIV-1, wraps to 0; units-remaining counter 3 bits.
//    Last cycle of a gap state: next edge -> IDLE; back-to-back chars have no dead cycle
//    beyond the one IDLE cycle used for the handshake.
//  - oBUSY = (state != IDLE). tone_cnt free-runs, width TONE_BIT+1, wraps naturally.
//  - Element index counts up 0..len-1; len latched at transfer, never re-read.
// STRUCTURE
//  - Package morse_pkg: state enum, code entry struct {len[2:0], pat[4:0]}, gap-length
//    constants (ELEM=1, CHAR=3, WORD_EXTRA=4, DOT=1, DASH=3).
//  - Sub-module morse_codebook: combinational ASCII -> {valid, is_space, len, pat} ROM.
//  - Top: FSM, prescaler, unit counter, element index, tone counter.
// TESTING (UNIT_DIV=4, TONE_BIT=2)
//  - 'E' (0x45) one-cycle valid -> oKEY 1 for 4 cycles, 0 for 12; oBUSY 16; oREADY again.
//  - 'K' -> oKEY high 12, low 4, high 4, low 4, high 12, then low 12 before oREADY=1.
//  - 'e' then ' ' held valid -> same waveform as 'E', then 16 cycles low with oBUSY=1;
//    second char accepted the first cycle oREADY returns.
//  - '#' (0x23) -> consumed in one cycle, oREADY stays 1, oBUSY and oKEY stay 0.
//  - '0' (5 dashes) -> 5 marks of 12 with 4-cycle gaps, final 12-cycle gap; total 88.
//  - iRST_N=0 for one edge mid-dash of 'T' -> oKEY=0, oBUSY=0, oREADY=1 after that edge;
//    oSOUND toggles every 4 cycles only while oKEY=1.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse keyer: FSM states, codebook entry
// layout, and gap/mark lengths in Morse units.
package morse_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_ELEM_GAP,
    S_CHAR_GAP,
    S_WORD_GAP
  } state_t;

  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pat;
  } code_t;

  localparam logic [2:0] U_ELEM       = 3'd1;
  localparam logic [2:0] U_CHAR       = 3'd3;
  localparam logic [2:0] U_WORD_EXTRA = 3'd4;
  localparam logic [2:0] U_DOT        = 3'd1;
  localparam logic [2:0] U_DASH       = 3'd3;

  // Element idx of a code; element 0 is the MSB of the len-bit pattern.
  function automatic logic elem_bit(input code_t c, input logic [2:0] idx);
    logic [7:0] p;
    logic [2:0] sel;
    p   = {3'b000, c.pat};
    sel = c.len - 3'd1 - idx;
    return p[sel];
  endfunction

  function automatic logic [2:0] mark_units(input logic dash);
    return dash ? U_DASH : U_DOT;
  endfunction

endpackage

// File: rtl/morse_codebook.sv
// Combinational ASCII -> Morse lookup. Lowercase folds to uppercase; space is flagged
// separately; anything else reports neither valid nor space.
module morse_codebook
  import morse_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_valid,
  output logic       o_space,
  output code_t      o_code
);

  logic [7:0] w_up;
  assign w_up = (i_char >= 8'h61 && i_char <= 8'h7A) ? i_char - 8'd32 : i_char;

  always_comb begin
    o_valid = 1'b1;
    o_space = 1'b0;
    o_code  = '0;
    case (w_up)
      "A": o_code = {3'd2, 5'b00001};
      "B": o_code = {3'd4, 5'b01000};
      "C": o_code = {3'd4, 5'b01010};
      "D": o_code = {3'd3, 5'b00100};
      "E": o_code = {3'd1, 5'b00000};
      "F": o_code = {3'd4, 5'b00010};
      "G": o_code = {3'd3, 5'b00110};
      "H": o_code = {3'd4, 5'b00000};
      "I": o_code = {3'd2, 5'b00000};
      "J": o_code = {3'd4, 5'b00111};
      "K": o_code = {3'd3, 5'b00101};
      "L": o_code = {3'd4, 5'b00100};
      "M": o_code = {3'd2, 5'b00011};
      "N": o_code = {3'd2, 5'b00010};
      "O": o_code = {3'd3, 5'b00111};
      "P": o_code = {3'd4, 5'b00110};
      "Q": o_code = {3'd4, 5'b01101};
      "R": o_code = {3'd3, 5'b00010};
      "S": o_code = {3'd3, 5'b00000};
      "T": o_code = {3'd1, 5'b00001};
      "U": o_code = {3'd3, 5'b00001};
      "V": o_code = {3'd4, 5'b00001};
      "W": o_code = {3'd3, 5'b00011};
      "X": o_code = {3'd4, 5'b01001};
      "Y": o_code = {3'd4, 5'b01011};
      "Z": o_code = {3'd4, 5'b01100};
      "0": o_code = {3'd5, 5'b11111};
      "1": o_code = {3'd5, 5'b01111};
      "2": o_code = {3'd5, 5'b00111};
      "3": o_code = {3'd5, 5'b00011};
      "4": o_code = {3'd5, 5'b00001};
      "5": o_code = {3'd5, 5'b00000};
      "6": o_code = {3'd5, 5'b10000};
      "7": o_code = {3'd5, 5'b11000};
      "8": o_code = {3'd5, 5'b11100};
      "9": o_code = {3'd5, 5'b11110};
      " ": begin
        o_valid = 1'b0;
        o_space = 1'b1;
      end
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_char_sequencer.sv
// Character-level Morse keyer: accepts ASCII over valid/ready, times marks and gaps in
// units of UNIT_DIV clocks, and gates a free-running tone onto the speaker output.
module morse_char_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_DIV = 12500000,
  parameter int TONE_BIT = 17
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iCHAR,
  input  logic       iVALID,
  output logic       oREADY,
  output logic       oKEY,
  output logic       oSOUND,
  output logic       oBUSY
);

  localparam int PW = $clog2(UNIT_DIV);

  state_t          r_state;
  logic [PW-1:0]   r_pre;
  logic [2:0]      r_units;
  logic [2:0]      r_idx;
  code_t           r_code;
  logic            r_key;
  logic [TONE_BIT:0] r_tone;

  logic  w_valid, w_space, w_xfer, w_tick, w_unit_done, w_last;
  code_t w_code;

  morse_codebook u_codebook (
    .i_char (iCHAR),
    .o_valid(w_valid),
    .o_space(w_space),
    .o_code (w_code)
  );

  assign oREADY      = (r_state == S_IDLE);
  assign oBUSY       = (r_state != S_IDLE);
  assign oKEY        = r_key;
  assign oSOUND      = r_key & r_tone[TONE_BIT];
  assign w_xfer      = iVALID && oREADY;
  assign w_tick      = (r_pre == PW'(UNIT_DIV - 1));
  assign w_unit_done = w_tick && (r_units == 3'd1);
  assign w_last      = (r_idx == r_code.len - 3'd1);

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_units <= '0;
      r_idx   <= '0;
      r_code  <= '0;
      r_key   <= 1'b0;
      r_tone  <= '0;
    end else begin
      r_tone <= r_tone + 1'b1;
      // Prescaler wraps on the unit tick, so every state exit leaves it at zero.
      if (r_state != S_IDLE) begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
        if (w_tick && !w_unit_done) r_units <= r_units - 3'd1;
      end
      case (r_state)
        S_IDLE: if (w_xfer) begin
          r_pre <= '0;
          if (w_valid) begin
            r_state <= S_MARK;
            r_key   <= 1'b1;
            r_code  <= w_code;
            r_idx   <= '0;
            r_units <= mark_units(elem_bit(w_code, 3'd0));
          end else if (w_space) begin
            r_state <= S_WORD_GAP;
            r_units <= U_WORD_EXTRA;
          end
        end
        S_MARK: if (w_unit_done) begin
          r_key <= 1'b0;
          if (w_last) begin
            r_state <= S_CHAR_GAP;
            r_units <= U_CHAR;
          end else begin
            r_state <= S_ELEM_GAP;
            r_units <= U_ELEM;
            r_idx   <= r_idx + 3'd1;
          end
        end
        S_ELEM_GAP: if (w_unit_done) begin
          r_state <= S_MARK;
          r_key   <= 1'b1;
          r_units <= mark_units(elem_bit(r_code, r_idx));
        end
        S_CHAR_GAP, S_WORD_GAP: if (w_unit_done) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_char_sequencer.sv
// Bench for morse_char_sequencer: a queue model expands characters from Morse strings
// into per-cycle key levels and is compared against the DUT every cycle.
module tb_morse_char_sequencer;

  localparam int U = 4;
  typedef bit bitq_t[$];

  logic       iCLK = 1'b0;
  logic       iRST_N, iVALID;
  logic [7:0] iCHAR;
  logic       oREADY, oKEY, oSOUND, oBUSY;

  int    errors = 0;
  int    checks = 0;
  int    tone   = 0;
  int    cyc    = 0;
  bitq_t q;

  morse_char_sequencer #(.UNIT_DIV(U), .TONE_BIT(2)) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iCHAR (iCHAR),
    .iVALID(iVALID),
    .oREADY(oREADY),
    .oKEY  (oKEY),
    .oSOUND(oSOUND),
    .oBUSY (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  function automatic string morse_of(input logic [7:0] u);
    case (u)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      default: return "";
    endcase
  endfunction

  // Per-cycle key levels from the transfer edge until the sequencer is idle again.
  function automatic bitq_t expand(input logic [7:0] c);
    bitq_t      r;
    string      s;
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'd32 : c;
    if (u == " ") begin
      repeat (4 * U) r.push_back(1'b0);
      return r;
    end
    s = morse_of(u);
    for (int i = 0; i < s.len(); i++) begin
      repeat ((s[i] == "-") ? 3 * U : U) r.push_back(1'b1);
      repeat ((i == s.len() - 1) ? 3 * U : U) r.push_back(1'b0);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    bit busy, key, snd;
    @(posedge iCLK);
    cyc++;
    if (!iRST_N) begin
      q.delete();
      tone = 0;
    end else begin
      tone = (tone + 1) % 8;
      if (q.size() != 0) void'(q.pop_front());
      else if (iVALID) q = expand(iCHAR);
    end
    @(negedge iCLK);
    busy = (q.size() != 0);
    key  = busy ? q[0] : 1'b0;
    snd  = key && (((tone >> 2) & 1) != 0);
    chk($sformatf("key@%0d", cyc),   oKEY,   key);
    chk($sformatf("busy@%0d", cyc),  oBUSY,  busy);
    chk($sformatf("ready@%0d", cyc), oREADY, !busy);
    chk($sformatf("sound@%0d", cyc), oSOUND, snd);
  endtask

  task automatic send(input logic [7:0] c, input bit hold, output int n);
    bit acc;
    iCHAR  = c;
    iVALID = 1'b1;
    n      = 0;
    acc    = 1'b0;
    while (!acc && n < 300) begin
      acc = (oREADY === 1'b1);
      step();
      n++;
    end
    chk($sformatf("accept_%0s", c), acc, 1);
    if (!hold) iVALID = 1'b0;
  endtask

  task automatic measure(input string name, input int eb, input int ek);
    int b, k, g;
    b = 0; k = 0; g = 0;
    while (oBUSY === 1'b1 && g < 300) begin
      b++;
      if (oKEY === 1'b1) k++;
      step();
      g++;
    end
    chk({name, "_busy_cycles"}, b, eb);
    chk({name, "_key_cycles"},  k, ek);
  endtask

  initial begin
    int    n;
    bitq_t t;
    iRST_N = 1'b0;
    iVALID = 1'b0;
    iCHAR  = 8'h00;
    repeat (3) step();
    chk("rst_key",   oKEY,   0);
    chk("rst_busy",  oBUSY,  0);
    chk("rst_ready", oREADY, 1);
    chk("rst_sound", oSOUND, 0);
    iRST_N = 1'b1;
    repeat (2) step();

    // Pin the model against hand-derived waveform lengths.
    t = expand("E"); chk("model_len_E", t.size(), 16);
    t = expand("K"); chk("model_len_K", t.size(), 48);
    t = expand("k"); chk("model_len_k", t.size(), 48);
    t = expand("0"); chk("model_len_0", t.size(), 88);
    t = expand(" "); chk("model_len_sp", t.size(), 16);
    t = expand("#"); chk("model_len_hash", t.size(), 0);

    send("E", 0, n); measure("E", 16, 4);
    step();
    send("K", 0, n); measure("K", 48, 28);

    send("e", 1, n);
    send(" ", 0, n);
    chk("space_accept_wait", n, 17);
    measure("space", 16, 0);

    send("#", 0, n);
    chk("hash_ready", oREADY, 1);
    chk("hash_busy",  oBUSY,  0);
    measure("hash", 0, 0);

    send("0", 0, n); measure("zero", 88, 60);

    send("T", 0, n);
    repeat (5) step();
    chk("T_mid_key", oKEY, 1);
    iRST_N = 1'b0;
    step();
    iRST_N = 1'b1;
    chk("midrst_key",   oKEY,   0);
    chk("midrst_busy",  oBUSY,  0);
    chk("midrst_ready", oREADY, 1);

    send("a", 0, n); measure("a", 32, 16);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
